// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA frame scheduler.
package vga_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int act, input int fp, input int pulse, input int bp);
    return act + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus region FSM (ACTIVE->FRONT->SYNC->BACK).
// Advances only when i_en is high; o_wrap flags the enabled cycle at the last count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int PULSE_LEN  = DEF_H_PULSE,
  parameter int BP_LEN     = DEF_H_BP,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output region_t          o_region,
  output logic             o_wrap,
  output logic             o_sync
);

  localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, PULSE_LEN, BP_LEN);
  localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE_LEN + FP_LEN + PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_count;
  region_t          r_region;
  region_t          w_region_next;

  assign o_wrap   = i_en & (r_count == LAST_CNT);
  assign o_count  = r_count;
  assign o_region = r_region;
  assign o_sync   = (r_region == SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_region <= ACTIVE;
    end else begin
      r_region <= w_region_next;
      if (i_en) r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

  // Region moves on the enabled cycle at the last count of the current region.
  always_comb begin
    w_region_next = r_region;
    if (i_en) begin
      case (r_region)
        ACTIVE:  if (r_count == LAST_ACT)  w_region_next = FRONT;
        FRONT:   if (r_count == LAST_FP)   w_region_next = SYNC;
        SYNC:    if (r_count == LAST_SYNC) w_region_next = BACK;
        BACK:    if (r_count == LAST_CNT)  w_region_next = ACTIVE;
        default: w_region_next = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA timing master and single-port framebuffer scheduler: display reads own phase 0
// of active pixels, the writer gets every other slot.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_PULSE  = DEF_H_PULSE,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_PULSE  = DEF_V_PULSE,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   ADDR_W   = 19,
  parameter int   DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_PULSE, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_PULSE, V_BP);
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

  logic              r_phase;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [DATA_W-1:0] r_pixel;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_video_on;
  logic              r_wr_err;

  logic [HC_W-1:0] w_hcount;
  logic [VC_W-1:0] w_vcount;
  region_t         w_hregion;
  region_t         w_vregion;
  logic            w_hwrap;
  logic            w_vwrap;
  logic            w_hsync_raw;
  logic            w_vsync_raw;
  logic            w_tick;
  logic            w_active;
  logic            w_rd;
  logic            w_slot;
  logic            w_in_range;

  assign w_tick = r_phase;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .PULSE_LEN  (H_PULSE),
    .BP_LEN     (H_BP),
    .CNT_W      (HC_W)
  ) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_tick),
    .o_count  (w_hcount),
    .o_region (w_hregion),
    .o_wrap   (w_hwrap),
    .o_sync   (w_hsync_raw)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .PULSE_LEN  (V_PULSE),
    .BP_LEN     (V_BP),
    .CNT_W      (VC_W)
  ) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_hwrap),
    .o_count  (w_vcount),
    .o_region (w_vregion),
    .o_wrap   (w_vwrap),
    .o_sync   (w_vsync_raw)
  );

  // Phase 0 of an active pixel belongs to the display; every other cycle is a write slot.
  assign w_active   = (w_hregion == ACTIVE) && (w_vregion == ACTIVE);
  assign w_rd       = ~r_phase & w_active;
  assign w_slot     = r_phase | ~w_active;
  assign w_in_range = ({1'b0, wr_addr} < FB_SIZE);

  assign wr_gnt      = wr_req & w_slot & ~rst;
  assign mem_we      = wr_gnt & w_in_range;
  assign mem_addr    = w_rd ? r_disp_addr : wr_addr;
  assign mem_wdata   = wr_data;
  assign frame_start = w_tick & (w_hcount == '0) & (w_vcount == '0);

  assign pixel    = r_pixel;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
  assign wr_err   = r_wr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 1'b0;
      r_disp_addr <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      r_phase  <= ~r_phase;
      r_wr_err <= wr_gnt & ~w_in_range;
      // Running raster address avoids a v*H_ACTIVE multiplier.
      if (w_tick & w_vwrap) r_disp_addr <= '0;
      else if (w_rd)        r_disp_addr <= r_disp_addr + 1'b1;
    end
  end

  // Read data returns on the tick cycle, so pins land one pixel period after the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel    <= '0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
    end else if (w_tick) begin
      r_pixel    <= w_active ? mem_rdata : '0;
      r_hsync    <= w_hsync_raw ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vsync_raw ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_active;
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized bench for vga_frame_scheduler on a shrunk raster, checked against a
// pixel-period reference model computed from the clock count since reset.
`timescale 1ns/1ps
module tb_vga_frame_scheduler;

  localparam int HA = 16, HF = 4, HP = 6, HB = 5;
  localparam int VA = 8,  VF = 2, VP = 2, VB = 3;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;
  localparam int FB = HA * VA;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tb_clear = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, wr_err, mem_we, hsync, vsync, video_on, frame_start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, pixel;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int n = 0;
  int last_fs = -1;
  logic [DW-1:0] fb [0:FB-1];
  logic [DW-1:0] rd_snap;
  logic [DW-1:0] e_pix;
  logic e_hs, e_vs, e_von, e_err;

  vga_frame_scheduler #(
    .H_ACTIVE (HA), .H_FP (HF), .H_PULSE (HP), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_PULSE (VP), .V_BP (VB),
    .SYNC_POL (1'b0), .ADDR_W (AW), .DATA_W (DW)
  ) dut (
    .clk (clk), .rst (rst),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data),
    .wr_gnt (wr_gnt), .wr_err (wr_err),
    .mem_addr (mem_addr), .mem_we (mem_we), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .pixel (pixel), .hsync (hsync), .vsync (vsync), .video_on (video_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM with 1-cycle registered read.
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h n=%0d t=%0t", tag, got, exp, n, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    last_fs = -1;
    e_pix = '0;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_von = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_pixel"}, pixel, 0);
    check_eq({tag, "_hsync"}, hsync, 1);
    check_eq({tag, "_vsync"}, vsync, 1);
    check_eq({tag, "_video_on"}, video_on, 0);
    check_eq({tag, "_wr_gnt"}, wr_gnt, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_wr_err"}, wr_err, 0);
    check_eq({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wr_req = 1'b1;
    wr_addr = AW'(FB);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      check_reset("rst");
    end
    model_reset();
  endtask

  // One clock: drive, check against the model, then advance the model.
  task automatic step();
    int p, ph, h, v;
    logic act, e_gnt, in_rng;
    rst = 1'b0;
    wr_req = ($urandom_range(0, 2) != 0);
    if ($urandom_range(0, 7) == 0) wr_addr = AW'($urandom_range(FB, (1 << AW) - 1));
    else                           wr_addr = AW'($urandom_range(0, FB - 1));
    wr_data = DW'($urandom);
    p  = n / 2;
    ph = n % 2;
    h  = p % HT;
    v  = (p / HT) % VT;
    act    = (h < HA) && (v < VA);
    e_gnt  = wr_req && (ph == 1 || !act);
    in_rng = (int'(wr_addr) < FB);
    #1;
    check_eq("pixel", pixel, e_pix);
    check_eq("hsync", hsync, e_hs);
    check_eq("vsync", vsync, e_vs);
    check_eq("video_on", video_on, e_von);
    check_eq("wr_err", wr_err, e_err);
    check_eq("wr_gnt", wr_gnt, e_gnt);
    check_eq("mem_we", mem_we, e_gnt && in_rng);
    check_eq("frame_start", frame_start, (ph == 1 && h == 0 && v == 0));
    if (ph == 0 && act) begin
      check_eq("rd_addr", mem_addr, v * HA + h);
    end else if (e_gnt && in_rng) begin
      check_eq("wr_addr", mem_addr, wr_addr);
      check_eq("wr_data", mem_wdata, wr_data);
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check_eq("fs_period", n - last_fs, FRAME_CLK);
      last_fs = n;
    end
    if (e_gnt)
      $display("wr n=%0d h=%0d v=%0d addr=%0d data=%02h stored=%0d", n, h, v, wr_addr, wr_data, in_rng);
    // The display read sees memory before any write later in the same pixel period.
    if (ph == 0 && act) rd_snap = fb[v * HA + h];
    if (e_gnt && in_rng) fb[wr_addr] = wr_data;
    e_err = e_gnt && !in_rng;
    if (ph == 1) begin
      e_von = act;
      e_pix = act ? rd_snap : '0;
      e_hs  = !(h >= HA + HF && h < HA + HF + HP);
      e_vs  = !(v >= VA + VF && v < VA + VF + VP);
    end
    n++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < FB; i++) fb[i] = '0;
    rd_snap = '0;
    model_reset();
    do_reset(3);
    tb_clear = 1'b0;
    for (int i = 0; i < 4 * FRAME_CLK; i++) step();
    // Run to the middle of an active line, then reset for a single clock.
    for (int i = 0; i < FRAME_CLK && !(n % 2 == 0 && (n / 2) % (HT * VT) == 5 * HT + 10); i++) step();
    do_reset(1);
    for (int i = 0; i < 2 * FRAME_CLK + 50; i++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
